// File: rtl/pool_engine.sv
// Sequential pooling engine: latches one activation map, walks every pooling window
// one element per cycle (NONE/MAX/AVG) and serves results through a multi-lane read port.
module pool_engine #(
    parameter int IN_H   = 8,
    parameter int IN_W   = 8,
    parameter int DATA_W = 16,
    parameter int BIN_W  = 8,
    parameter int LANES  = 4,
    parameter int MAX_K  = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [IN_H*IN_W*DATA_W-1:0]       af_in,
    input  logic [1:0]                        pool_type,
    input  logic [$clog2(MAX_K+1)-1:0]        kernel,
    input  logic [$clog2(MAX_K+1)-1:0]        stride,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err,
    output logic [$clog2(IN_H+1)-1:0]         out_h,
    output logic [$clog2(IN_W+1)-1:0]         out_w,
    input  logic                              rd_en,
    input  logic [$clog2(IN_H)-1:0]           rd_r,
    input  logic [$clog2(IN_W)-1:0]           rd_c,
    output logic [LANES*BIN_W-1:0]            rd_data,
    output logic                              rd_valid
);

    localparam int KW    = $clog2(MAX_K+1);
    localparam int HW    = $clog2(IN_H+1);
    localparam int WW    = $clog2(IN_W+1);
    localparam int NE    = IN_H*IN_W;
    localparam int AW    = (NE > 1) ? $clog2(NE) : 1;
    localparam int ACC_W = DATA_W + 4;

    localparam logic [1:0] PT_NONE = 2'd0;
    localparam logic [1:0] PT_MAX  = 2'd1;
    localparam logic [1:0] PT_AVG  = 2'd2;
    localparam logic [1:0] PT_RSVD = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           ptype_q, ptype_d;
    logic [KW-1:0]        k_q, k_d, s_q, s_d;
    logic [KW-1:0]        kr_q, kr_d, kc_q, kc_d;
    logic [HW-1:0]        pr_q, pr_d, out_h_q, out_h_d;
    logic [WW-1:0]        pc_q, pc_d, out_w_q, out_w_d;
    logic [ACC_W-1:0]     acc_q, acc_d, acc_n_s, x_ext_s;
    logic                 cfg_err_q, cfg_err_d, res_valid_q, res_valid_d;
    logic                 busy_q, done_q, rd_valid_q;
    logic [LANES*BIN_W-1:0] rd_data_q, rd_data_d;

    logic [DATA_W-1:0]    map_q [NE];
    logic [DATA_W-1:0]    buf_q [NE];

    logic                 map_we_s, buf_we_s, cfg_bad_s, rd_acc_s;
    logic                 first_s, last_kc_s, last_kr_s, last_pc_s, last_pr_s;
    logic [AW-1:0]        elem_idx_s, buf_idx_s, row_s, col_s;
    logic [DATA_W-1:0]    x_s, buf_val_s;
    logic [2:0]           avg_sh_s;
    logic [31:0]          s_div_s;
    logic [HW-1:0]        ph_s;
    logic [WW-1:0]        pw_s;

    // Values of 2^BIN_W and above clamp to the all-ones SRAM code.
    function automatic logic [BIN_W-1:0] sat_bin(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] hi;
        hi = v >> BIN_W;
        if (hi != '0) begin
            sat_bin = '1;
        end else begin
            sat_bin = v[BIN_W-1:0];
        end
    endfunction

    // Configuration checks, output dimensions and AVG shift from the latched config.
    always_comb begin
        cfg_bad_s = (k_q == '0) || (s_q == '0) ||
                    (32'(k_q) > 32'(IN_H)) || (32'(k_q) > 32'(IN_W)) ||
                    (32'(k_q) > 32'(MAX_K)) || (32'(s_q) > 32'(MAX_K)) ||
                    (ptype_q == PT_RSVD) ||
                    ((ptype_q == PT_AVG) && (k_q != KW'(32'd1)) &&
                     (k_q != KW'(32'd2)) && (k_q != KW'(32'd4)));
        s_div_s = (s_q == '0) ? 32'd1 : 32'(s_q);
        ph_s    = HW'((32'(IN_H) - 32'(k_q)) / s_div_s + 32'd1);
        pw_s    = WW'((32'(IN_W) - 32'(k_q)) / s_div_s + 32'd1);
        case (k_q)
            KW'(32'd4): avg_sh_s = 3'd4;
            KW'(32'd2): avg_sh_s = 3'd2;
            default:    avg_sh_s = 3'd0;
        endcase
    end

    // Window walk addressing: current input element and loop-end flags.
    always_comb begin
        row_s      = AW'(pr_q) * AW'(s_q) + AW'(kr_q);
        col_s      = AW'(pc_q) * AW'(s_q) + AW'(kc_q);
        elem_idx_s = row_s * AW'(IN_W) + col_s;
        x_s        = map_q[elem_idx_s];
        x_ext_s    = ACC_W'(x_s);
        first_s    = (kr_q == '0) && (kc_q == '0);
        last_kc_s  = (kc_q == k_q - KW'(1'b1));
        last_kr_s  = (kr_q == k_q - KW'(1'b1));
        last_pc_s  = (pc_q == out_w_q - WW'(1'b1));
        last_pr_s  = (pr_q == out_h_q - HW'(1'b1));
    end

    // Control FSM next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        ptype_d     = ptype_q;
        k_d         = k_q;
        s_d         = s_q;
        pr_d        = pr_q;
        pc_d        = pc_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        acc_d       = acc_q;
        cfg_err_d   = cfg_err_q;
        res_valid_d = res_valid_q;
        out_h_d     = out_h_q;
        out_w_d     = out_w_q;
        map_we_s    = 1'b0;
        buf_we_s    = 1'b0;
        buf_idx_s   = '0;
        buf_val_s   = '0;
        acc_n_s     = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    map_we_s    = 1'b1;
                    ptype_d     = pool_type;
                    k_d         = (pool_type == PT_NONE) ? KW'(32'd1) : kernel;
                    s_d         = (pool_type == PT_NONE) ? KW'(32'd1) : stride;
                    cfg_err_d   = 1'b0;
                    res_valid_d = 1'b0;
                    pr_d        = '0;
                    pc_d        = '0;
                    kr_d        = '0;
                    kc_d        = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (cfg_bad_s) begin
                    cfg_err_d = 1'b1;
                    out_h_d   = '0;
                    out_w_d   = '0;
                    state_d   = S_DONE;
                end else begin
                    out_h_d = ph_s;
                    out_w_d = pw_s;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (first_s) begin
                    acc_n_s = x_ext_s;
                end else if (ptype_q == PT_AVG) begin
                    acc_n_s = acc_q + x_ext_s;
                end else begin
                    acc_n_s = (x_ext_s > acc_q) ? x_ext_s : acc_q;
                end
                acc_d = acc_n_s;
                if (last_kc_s && last_kr_s) begin
                    buf_we_s  = 1'b1;
                    buf_idx_s = AW'(pr_q) * AW'(IN_W) + AW'(pc_q);
                    buf_val_s = (ptype_q == PT_AVG) ? DATA_W'(acc_n_s >> avg_sh_s)
                                                    : DATA_W'(acc_n_s);
                end else begin
                    buf_we_s = 1'b0;
                end
                // Nested raster counters: kc fastest, then kr, pc, pr.
                if (!last_kc_s) begin
                    kc_d = kc_q + KW'(1'b1);
                end else begin
                    kc_d = '0;
                    if (!last_kr_s) begin
                        kr_d = kr_q + KW'(1'b1);
                    end else begin
                        kr_d = '0;
                        if (!last_pc_s) begin
                            pc_d = pc_q + WW'(1'b1);
                        end else begin
                            pc_d = '0;
                            if (!last_pr_s) begin
                                pr_d = pr_q + HW'(1'b1);
                            end else begin
                                pr_d    = '0;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                res_valid_d = ~cfg_err_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read lanes: masked outside PH x PW, refused while busy, unvalidated or starting.
    always_comb begin
        rd_acc_s  = rd_en && res_valid_q && !busy_q && !start;
        rd_data_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rd_acc_s && (32'(rd_r) < 32'(out_h_q)) &&
                (32'(rd_c) + 32'(i) < 32'(out_w_q))) begin
                rd_data_d[i*BIN_W +: BIN_W] =
                    sat_bin(buf_q[AW'(32'(rd_r) * 32'(IN_W) + 32'(rd_c) + 32'(i))]);
            end else begin
                rd_data_d[i*BIN_W +: BIN_W] = '0;
            end
        end
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptype_q     <= 2'd0;
            k_q         <= '0;
            s_q         <= '0;
            pr_q        <= '0;
            pc_q        <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            acc_q       <= '0;
            cfg_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            out_h_q     <= '0;
            out_w_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptype_q     <= ptype_d;
            k_q         <= k_d;
            s_q         <= s_d;
            pr_q        <= pr_d;
            pc_q        <= pc_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            acc_q       <= acc_d;
            cfg_err_q   <= cfg_err_d;
            res_valid_q <= res_valid_d;
            out_h_q     <= out_h_d;
            out_w_q     <= out_w_d;
            busy_q      <= (state_d == S_LOAD) || (state_d == S_COMPUTE);
            done_q      <= (state_q == S_DONE);
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_acc_s;
        end
    end

    // Map and result storage carry no reset; res_valid masks stale contents.
    always_ff @(posedge clock) begin
        if (map_we_s) begin
            for (int i = 0; i < NE; i++) begin
                map_q[i] <= af_in[i*DATA_W +: DATA_W];
            end
        end
        if (buf_we_s) begin
            buf_q[buf_idx_s] <= buf_val_s;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign out_h    = out_h_q;
    assign out_w    = out_w_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pool_engine.sv
// Directed self-checking bench for pool_engine on a 4x4 map with hand-computed results.
module tb_pool_engine;

    localparam int IN_H = 4, IN_W = 4, DATA_W = 16, BIN_W = 8, LANES = 4, MAX_K = 4;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic                        start = 1'b0;
    logic [IN_H*IN_W*DATA_W-1:0] af_in = '0;
    logic [1:0]                  pool_type = 2'd0;
    logic [2:0]                  kernel = 3'd0, stride = 3'd0;
    logic                        busy, done, cfg_err, rd_valid;
    logic [2:0]                  out_h, out_w;
    logic                        rd_en = 1'b0;
    logic [1:0]                  rd_r = 2'd0, rd_c = 2'd0;
    logic [LANES*BIN_W-1:0]      rd_data;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int cyc_cnt    = 0;
    int e0         = 0;
    int done_seen;

    pool_engine #(.IN_H(IN_H), .IN_W(IN_W), .DATA_W(DATA_W), .BIN_W(BIN_W),
                  .LANES(LANES), .MAX_K(MAX_K)) dut (
        .clock(clock), .reset(reset), .start(start), .af_in(af_in),
        .pool_type(pool_type), .kernel(kernel), .stride(stride),
        .busy(busy), .done(done), .cfg_err(cfg_err), .out_h(out_h), .out_w(out_w),
        .rd_en(rd_en), .rd_r(rd_r), .rd_c(rd_c), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt++;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ramp();
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                af_in[(r*IN_W+c)*DATA_W +: DATA_W] = 16'(4*r + c);
    endtask

    task automatic start_pass(input logic [1:0] pt, input logic [2:0] k, input logic [2:0] s);
        pool_type = pt;
        kernel    = k;
        stride    = s;
        start     = 1'b1;
        @(posedge clock);
        #1;
        e0    = cyc_cnt;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string tag);
        int n;
        n = 0;
        while (n < 300) begin
            @(posedge clock);
            #1;
            n++;
            if (done) break;
        end
        check_val(tag, 64'(cyc_cnt - e0), 64'(exp_cyc));
    endtask

    task automatic do_read(input logic [1:0] r, input logic [1:0] c, input logic exp_v,
                           input logic [31:0] exp_d, input string tag);
        rd_r  = r;
        rd_c  = c;
        rd_en = 1'b1;
        @(posedge clock);
        #1;
        rd_en = 1'b0;
        check_val({tag, "_valid"}, 64'(rd_valid), 64'(exp_v));
        check_val({tag, "_data"}, 64'(rd_data), 64'(exp_d));
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_err", 64'(cfg_err), 64'd0);
        check_val("rst_oh", 64'(out_h), 64'd0);
        check_val("rst_ow", 64'(out_w), 64'd0);
        check_val("rst_rdv", 64'(rd_valid), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_read(2'd0, 2'd0, 1'b0, 32'h0, "rd_after_rst");

        // MAX K=2 S=2
        set_ramp();
        start_pass(2'd1, 3'd2, 3'd2);
        check_val("max_busy", 64'(busy), 64'd1);
        wait_done(18, "max_cyc");
        check_val("max_oh", 64'(out_h), 64'd2);
        check_val("max_ow", 64'(out_w), 64'd2);
        check_val("max_err", 64'(cfg_err), 64'd0);
        check_val("max_busy_end", 64'(busy), 64'd0);
        do_read(2'd0, 2'd0, 1'b1, 32'h0000_0705, "max_r0");
        check_val("done_pulse", 64'(done), 64'd0);
        do_read(2'd1, 2'd0, 1'b1, 32'h0000_0F0D, "max_r1");

        // AVG K=2 S=2
        start_pass(2'd2, 3'd2, 3'd2);
        wait_done(18, "avg_cyc");
        do_read(2'd0, 2'd0, 1'b1, 32'h0000_0402, "avg_r0");
        do_read(2'd1, 2'd0, 1'b1, 32'h0000_0C0A, "avg_r1");
        do_read(2'd0, 2'd1, 1'b1, 32'h0000_0004, "avg_edge");
        do_read(2'd3, 2'd0, 1'b1, 32'h0000_0000, "avg_row_oob");

        // AVG K=3: configuration error
        start_pass(2'd2, 3'd3, 3'd1);
        wait_done(2, "err_cyc");
        check_val("err_flag", 64'(cfg_err), 64'd1);
        check_val("err_oh", 64'(out_h), 64'd0);
        do_read(2'd0, 2'd0, 1'b0, 32'h0, "err_rd");

        // MAX K=3 S=1
        start_pass(2'd1, 3'd3, 3'd1);
        wait_done(38, "max3_cyc");
        check_val("max3_err", 64'(cfg_err), 64'd0);
        do_read(2'd0, 2'd0, 1'b1, 32'h0000_0B0A, "max3_r0");
        do_read(2'd1, 2'd0, 1'b1, 32'h0000_0F0E, "max3_r1");

        // NONE with saturation; kernel/stride inputs are overridden
        af_in[0*DATA_W +: DATA_W] = 16'd300;
        af_in[1*DATA_W +: DATA_W] = 16'd255;
        start_pass(2'd0, 3'd3, 3'd2);
        wait_done(18, "none_cyc");
        check_val("none_oh", 64'(out_h), 64'd4);
        check_val("none_ow", 64'(out_w), 64'd4);
        do_read(2'd0, 2'd0, 1'b1, 32'h0302_FFFF, "none_r0");
        do_read(2'd2, 2'd1, 1'b1, 32'h000B_0A09, "none_r2");

        // rd_en with start refused; start and rd_en during COMPUTE ignored/refused
        set_ramp();
        rd_r  = 2'd0;
        rd_c  = 2'd0;
        rd_en = 1'b1;
        start_pass(2'd1, 3'd2, 3'd2);
        rd_en = 1'b0;
        check_val("rd_start_v", 64'(rd_valid), 64'd0);
        check_val("rd_start_d", 64'(rd_data), 64'd0);
        repeat (5) @(posedge clock);
        #1;
        pool_type = 2'd2;
        start     = 1'b1;
        rd_en     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        rd_en = 1'b0;
        check_val("mid_busy", 64'(busy), 64'd1);
        check_val("mid_rd_v", 64'(rd_valid), 64'd0);
        check_val("mid_rd_d", 64'(rd_data), 64'd0);
        wait_done(18, "mid_cyc");
        do_read(2'd0, 2'd0, 1'b1, 32'h0000_0705, "mid_keep");

        // Reset mid-pass
        start_pass(2'd1, 3'd2, 3'd2);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_val("rmid_busy", 64'(busy), 64'd0);
        check_val("rmid_done", 64'(done), 64'd0);
        #3;
        reset     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) done_seen++;
        end
        check_val("rmid_nodone", 64'(done_seen), 64'd0);
        do_read(2'd0, 2'd0, 1'b0, 32'h0, "rmid_rd");
        start_pass(2'd2, 3'd2, 3'd2);
        wait_done(18, "rmid_cyc");
        do_read(2'd1, 2'd0, 1'b1, 32'h0000_0C0A, "rmid_avg");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
